tlptap_arb: RTL and testbench
=============================

TLPTAP_ARB -- requirements
Module: tlptap_arb

Interface
REQ-001 C_DATA_WIDTH, 64, tap data width in bits.
REQ-002 KEEP_WIDTH, C_DATA_WIDTH/32, dword-granular keep width; 2 for the 64-bit datapath.
REQ-003 TIMEOUT, 256, max idle cycles inside a granted packet before abort; range 2..65535.
REQ-004 clk156  in  1  single clock; all logic on its rising edge.
REQ-005 sys_rst_n  in  1  reset, synchronous, active-low.
REQ-006 s0_tdata/s1_tdata  in  C_DATA_WIDTH  tap stream data for port 0 / port 1.
REQ-007 s0_tkeep/s1_tkeep  in  KEEP_WIDTH  dword keep, one bit per 32-bit lane.
REQ-008 s0_tlast/s1_tlast, s0_tuser/s1_tuser, s0_tvalid/s1_tvalid  in  1 each  end-of-packet, error flag, valid.
REQ-009 s0_tready/s1_tready  out  1 each  word accepted when tvalid and tready are both high.
REQ-010 wr_en  out  1  FIFO write strobe.
REQ-011 din  out  74  FIFO word {keep8, tdata64, tlast, tuser}.
REQ-012 full  in  1  FIFO full.
REQ-013 wr_src  out  1  source port of the current din word; valid with wr_en.
REQ-014 pkt_cnt0/pkt_cnt1  out  32 each  packets forwarded per port.
REQ-015 abort_cnt  out  16  timeout aborts, both ports combined.

Function
REQ-016 States: IDLE, GRANT, FLUSH, DROP; one grant register gnt (0/1) and one last-winner register lw.
REQ-017 IDLE: if exactly one port asserts tvalid, that port wins; if both assert tvalid, the port != lw wins; the winner is loaded into gnt, and the next state is GRANT.
REQ-018 GRANT: s<gnt>_tready = !full; the other port's tready = 0; on accept, wr_en = 1 in the same cycle (combinational, zero latency).
REQ-019 din keep8 = each keep bit replicated 4x, bit1 in [7:4] and bit0 in [3:0]; data, last and user are passed through unmodified.
REQ-020 Accepting a word with tlast = 1 updates lw := gnt, increments pkt_cnt<gnt>, and returns the FSM to IDLE; a new grant is never issued in that same cycle.
REQ-021 Grant is held for a whole packet; no interleaving of ports is permitted.
REQ-022 Idle counter: clears on every accepted word and on entry to GRANT; increments each GRANT cycle with s<gnt>_tvalid = 0; while full = 1, the counter holds its value.
REQ-023 Idle counter reaching TIMEOUT-1 -> FLUSH.
REQ-024 FLUSH: both treadys = 0; when !full, write one terminator word keep8 = 0, tdata = 0, tlast = 1, tuser = 1, with wr_src = gnt, then go to DROP and increment abort_cnt (saturating at 16'hFFFF).
REQ-025 DROP: s<gnt>_tready = 1 regardless of full, wr_en = 0, words are discarded; the accept with tlast = 1 -> IDLE with lw := gnt; no pkt_cnt increment.
REQ-026 pkt_cnt0/pkt_cnt1 wrap modulo 2^32.
REQ-027 full = 1 in GRANT stalls the stream; wr_en is never asserted while full = 1.
REQ-028 tready is never asserted in IDLE; arbitration costs exactly one cycle per packet.
REQ-029 Single-word packets (tlast on the first word) are legal and follow REQ-020.
REQ-030 A packet must not start with a tvalid drop: tvalid is sampled only in IDLE, and loss of tvalid after grant is covered by REQ-022.

Reset
REQ-031 sys_rst_n = 0 at a clock edge: state := IDLE, gnt := 0, lw := 1 (port 0 wins the first tie), idle counter := 0, pkt_cnt0/pkt_cnt1/abort_cnt := 0.
REQ-032 During reset and in the first cycle after it: wr_en = 0, s0_tready = s1_tready = 0, din = 0, wr_src = 0.
REQ-033 Reset mid-packet abandons the packet with no terminator word; upstream is responsible for its own flush.

Structure
REQ-034 A shared package tlptap_pkg holds the FSM state enum, the FIFO word width constant (74), and the keep-expansion function.
REQ-035 One sub-module, tlptap_rr2, performs the two-input round-robin pick (req[1:0], lw -> winner); all remaining logic stays in tlptap_arb.

Verification
REQ-036 Only s0 sends a 3-word packet, full = 0 -> grant in cycle 1; wr_en high for 3 consecutive cycles; keep 2'b01 -> keep8 8'h0F; pkt_cnt0 = 1.
REQ-037 s0 and s1 both valid out of reset, 2 words each -> s0 forwarded first, then s1 after one IDLE cycle; wr_src sequence 0,0,1,1.
REQ-038 full asserted for 5 cycles mid s1 packet -> s1_tready low for those 5 cycles, no wr_en, no data lost or duplicated; abort_cnt stays 0.
REQ-039 TIMEOUT = 4; s0 drops tvalid after word 1 -> terminator word {8'h00, 64'h0, 1, 1} written; abort_cnt = 1; remaining s0 words discarded up to tlast; pkt_cnt0 = 0.
REQ-040 sys_rst_n low for one cycle during word 2 of a 4-word s1 packet -> all outputs and counters return to 0 in the next cycle, and a subsequent s0 packet is forwarded normally.

Source files
------------

// File: rtl/tlptap_pkg.sv
// Shared types and helpers for the two-port TLP tap arbiter.
package tlptap_pkg;

  // FIFO word: {keep8, tdata64, tlast, tuser}
  localparam int TLP_DIN_W = 74;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DROP  = 2'd3
  } tap_state_t;

  typedef struct packed {
    logic [7:0]  keep8;
    logic [63:0] data;
    logic        last;
    logic        user;
  } fifo_word_t;

  // Dword keep -> byte keep: each lane bit covers four bytes.
  function automatic logic [7:0] keep_expand(input logic [1:0] keep);
    keep_expand = {{4{keep[1]}}, {4{keep[0]}}};
  endfunction

endpackage

// File: rtl/tlptap_rr2.sv
// Two-input round-robin pick: a lone requester wins, a tie goes to the
// port that did not win last time.
module tlptap_rr2 (
  input  logic [1:0] req,
  input  logic       lw,
  output logic       win
);

  // Winner select
  always_comb begin
    win = 1'b0;
    case (req)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      2'b11:   win = ~lw;
      default: win = 1'b0;
    endcase
  end

endmodule

// File: rtl/tlptap_arb.sv
// Two-port packet arbiter feeding a capture FIFO. A port is granted for a
// whole packet; a stalled source is aborted with a terminator word and the
// rest of its packet is drained and discarded.
module tlptap_arb
  import tlptap_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 32,
  parameter int TIMEOUT      = 256
) (
  input  logic                    clk156,
  input  logic                    sys_rst_n,
  input  logic [C_DATA_WIDTH-1:0] s0_tdata,
  input  logic [KEEP_WIDTH-1:0]   s0_tkeep,
  input  logic                    s0_tlast,
  input  logic                    s0_tuser,
  input  logic                    s0_tvalid,
  output logic                    s0_tready,
  input  logic [C_DATA_WIDTH-1:0] s1_tdata,
  input  logic [KEEP_WIDTH-1:0]   s1_tkeep,
  input  logic                    s1_tlast,
  input  logic                    s1_tuser,
  input  logic                    s1_tvalid,
  output logic                    s1_tready,
  output logic                    wr_en,
  output logic [TLP_DIN_W-1:0]    din,
  input  logic                    full,
  output logic                    wr_src,
  output logic [31:0]             pkt_cnt0,
  output logic [31:0]             pkt_cnt1,
  output logic [15:0]             abort_cnt
);

  // The idle counter advances to TIMEOUT-1 on the cycle it currently
  // holds TIMEOUT-2; that is the cycle that commits the move to FLUSH.
  localparam logic [15:0] IDLE_LIM = 16'(TIMEOUT - 2);

  tap_state_t state, state_nxt;
  logic       gnt, lw, win;
  logic [15:0] idle_cnt;

  logic [1:0]              req;
  logic [C_DATA_WIDTH-1:0] g_data;
  logic [KEEP_WIDTH-1:0]   g_keep;
  logic                    g_last, g_user, g_valid;

  logic       rdy, wr, acc;
  fifo_word_t word;

  assign req = {s1_tvalid, s0_tvalid};

  tlptap_rr2 u_rr2 (
    .req (req),
    .lw  (lw),
    .win (win)
  );

  // Granted-port source mux
  always_comb begin
    g_data  = s0_tdata;
    g_keep  = s0_tkeep;
    g_last  = s0_tlast;
    g_user  = s0_tuser;
    g_valid = s0_tvalid;
    if (gnt) begin
      g_data  = s1_tdata;
      g_keep  = s1_tkeep;
      g_last  = s1_tlast;
      g_user  = s1_tuser;
      g_valid = s1_tvalid;
    end
  end

  // Next-state, handshake and FIFO word generation
  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    wr        = 1'b0;
    word      = '0;
    case (state)
      ST_IDLE: begin
        if (|req) state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        rdy = ~full;
        if (g_valid && !full) begin
          wr         = 1'b1;
          word.keep8 = keep_expand(g_keep);
          word.data  = g_data;
          word.last  = g_last;
          word.user  = g_user;
          if (g_last) state_nxt = ST_IDLE;
        end else if (!g_valid && !full && idle_cnt == IDLE_LIM) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!full) begin
          wr        = 1'b1;
          word.last = 1'b1;
          word.user = 1'b1;
          state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        // Drain the aborted packet even when the FIFO is full
        rdy = 1'b1;
        if (g_valid && g_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign acc = g_valid & rdy;

  // Outputs are forced quiet while reset is asserted
  assign s0_tready = sys_rst_n & rdy & ~gnt;
  assign s1_tready = sys_rst_n & rdy & gnt;
  assign wr_en     = sys_rst_n & wr;
  assign din       = sys_rst_n ? word : '0;
  assign wr_src    = wr_en & gnt;

  // FSM state, grant and last-winner registers
  always_ff @(posedge clk156) begin
    if (!sys_rst_n) begin
      state <= ST_IDLE;
      gnt   <= 1'b0;
      lw    <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && |req) gnt <= win;
      if ((state == ST_GRANT || state == ST_DROP) && acc && g_last) lw <= gnt;
    end
  end

  // Idle counter: stalled-source detection inside a granted packet
  always_ff @(posedge clk156) begin
    if (!sys_rst_n) begin
      idle_cnt <= '0;
    end else if (state != ST_GRANT) begin
      idle_cnt <= '0;
    end else if (acc) begin
      idle_cnt <= '0;
    end else if (!full && !g_valid) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  // Per-port forwarded packet counters, wrapping
  always_ff @(posedge clk156) begin
    if (!sys_rst_n) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (state == ST_GRANT && acc && g_last) begin
      if (gnt) pkt_cnt1 <= pkt_cnt1 + 32'd1;
      else     pkt_cnt0 <= pkt_cnt0 + 32'd1;
    end
  end

  // Abort counter, saturating
  always_ff @(posedge clk156) begin
    if (!sys_rst_n) begin
      abort_cnt <= '0;
    end else if (state == ST_FLUSH && !full && abort_cnt != 16'hFFFF) begin
      abort_cnt <= abort_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_tlptap_arb.sv
// Self-checking bench for tlptap_arb (TIMEOUT = 4).
module tb_tlptap_arb;

  logic        clk156 = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [63:0] s0_tdata = '0, s1_tdata = '0;
  logic [1:0]  s0_tkeep = '0, s1_tkeep = '0;
  logic        s0_tlast = 1'b0, s1_tlast = 1'b0;
  logic        s0_tuser = 1'b0, s1_tuser = 1'b0;
  logic        s0_tvalid = 1'b0, s1_tvalid = 1'b0;
  logic        s0_tready, s1_tready;
  logic        wr_en, wr_src;
  logic [73:0] din;
  logic        full = 1'b0;
  logic [31:0] pkt_cnt0, pkt_cnt1;
  logic [15:0] abort_cnt;

  always #5 clk156 = ~clk156;

  tlptap_arb #(.C_DATA_WIDTH(64), .KEEP_WIDTH(2), .TIMEOUT(4)) dut (
    .clk156(clk156), .sys_rst_n(sys_rst_n),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tlast(s0_tlast), .s0_tuser(s0_tuser),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tlast(s1_tlast), .s1_tuser(s1_tuser),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .wr_en(wr_en), .din(din), .full(full), .wr_src(wr_src),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .abort_cnt(abort_cnt)
  );

  // One source beat; pre = cycles tvalid stays low before it is offered
  typedef struct { logic [63:0] data; logic [1:0] keep; logic last; logic user; int pre; } beat_t;
  typedef struct { int cyc; logic src; logic [73:0] word; } wlog_t;

  beat_t q0[$], q1[$];
  wlog_t wlog[$];
  int    w0, w1, cyc, viol, checks, errors;
  logic  smp_rdy0, smp_rdy1, smp_wr, smp_src;
  logic [73:0] smp_din;

  localparam logic [73:0] TERM = {8'h00, 64'h0, 1'b1, 1'b1};

  function automatic logic [7:0] kexp(input logic [1:0] k);
    kexp = (k[1] ? 8'hF0 : 8'h00) | (k[0] ? 8'h0F : 8'h00);
  endfunction

  function automatic logic [73:0] fword(input beat_t b);
    fword = {kexp(b.keep), b.data, b.last, b.user};
  endfunction

  function automatic beat_t mk(input logic [1:0] keep, input logic last, input int pre);
    beat_t b;
    b.data = {$urandom, $urandom};
    b.keep = keep;
    b.last = last;
    b.user = 1'($urandom_range(0, 1));
    b.pre  = pre;
    return b;
  endfunction

  // Drive one clock of source traffic, sample outputs at the falling edge,
  // retire handshaken beats and log every FIFO write.
  task automatic drive_cycle(input logic f);
    logic v0, v1;
    full = f;
    v0 = (q0.size() > 0) && (w0 >= q0[0].pre);
    v1 = (q1.size() > 0) && (w1 >= q1[0].pre);
    s0_tvalid = v0;
    s1_tvalid = v1;
    if (v0) begin s0_tdata = q0[0].data; s0_tkeep = q0[0].keep; s0_tlast = q0[0].last; s0_tuser = q0[0].user; end
    else begin s0_tdata = {$urandom, $urandom}; s0_tkeep = '0; s0_tlast = 1'b0; s0_tuser = 1'b0; end
    if (v1) begin s1_tdata = q1[0].data; s1_tkeep = q1[0].keep; s1_tlast = q1[0].last; s1_tuser = q1[0].user; end
    else begin s1_tdata = {$urandom, $urandom}; s1_tkeep = '0; s1_tlast = 1'b0; s1_tuser = 1'b0; end
    @(negedge clk156);
    smp_rdy0 = s0_tready; smp_rdy1 = s1_tready; smp_wr = wr_en; smp_din = din; smp_src = wr_src;
    if (wr_en) wlog.push_back('{cyc, wr_src, din});
    if (wr_en && full) viol++;
    if (s0_tready && s1_tready) viol++;
    if (v0 && s0_tready) begin q0.delete(0); w0 = 0; end else if (!v0 && q0.size() > 0) w0++;
    if (v1 && s1_tready) begin q1.delete(0); w1 = 0; end else if (!v1 && q1.size() > 0) w1++;
    @(posedge clk156); #1;
    cyc++;
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    q0.delete(); q1.delete(); w0 = 0; w1 = 0;
    full = 1'b0; s0_tvalid = 1'b0; s1_tvalid = 1'b0;
    repeat (2) @(posedge clk156);
    #1 sys_rst_n = 1'b1;
    wlog.delete(); viol = 0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; full = 1'b0;
    s0_tvalid = 1'b1; s1_tvalid = 1'b1; s0_tlast = 1'b1; s1_tlast = 1'b1;
    s0_tkeep = 2'b11; s1_tkeep = 2'b11; s0_tdata = {$urandom, $urandom}; s1_tdata = {$urandom, $urandom};
    @(posedge clk156); @(negedge clk156);
    checks++;
    if ({s0_tready, s1_tready, wr_en, wr_src} !== 4'b0000 || din !== 74'd0) begin
      errors++; $display("FAIL rst_hold rdy0/rdy1/wr/src=%b din=%h want 0", {s0_tready, s1_tready, wr_en, wr_src}, din);
    end
    @(posedge clk156); #1 sys_rst_n = 1'b1;
    @(negedge clk156);
    checks++;
    if ({s0_tready, s1_tready, wr_en, wr_src} !== 4'b0000 || din !== 74'd0) begin
      errors++; $display("FAIL rst_first rdy0/rdy1/wr/src=%b din=%h want 0", {s0_tready, s1_tready, wr_en, wr_src}, din);
    end
    checks++;
    if (pkt_cnt0 !== 32'd0 || pkt_cnt1 !== 32'd0 || abort_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_cnt got %0h/%0h/%0h want 0/0/0", pkt_cnt0, pkt_cnt1, abort_cnt);
    end
    s0_tvalid = 1'b0; s1_tvalid = 1'b0;
    @(posedge clk156); #1;
  endtask

  task automatic test_single_port();
    beat_t b[3];
    int c0;
    do_reset();
    b[0] = mk(2'b11, 1'b0, 0); b[1] = mk(2'b10, 1'b0, 0); b[2] = mk(2'b01, 1'b1, 0);
    for (int i = 0; i < 3; i++) q0.push_back(b[i]);
    c0 = cyc;
    for (int i = 0; i < 30 && q0.size() > 0; i++) drive_cycle(1'b0);
    repeat (2) drive_cycle(1'b0);
    checks++;
    if (wlog.size() != 3) begin errors++; $display("FAIL single_cnt got %0d want 3", wlog.size()); end
    for (int i = 0; i < 3 && i < wlog.size(); i++) begin
      checks++;
      if (wlog[i].cyc != c0 + 1 + i || wlog[i].src !== 1'b0 || wlog[i].word !== fword(b[i])) begin
        errors++; $display("FAIL single_w%0d got cyc %0d src %b %h want cyc %0d src 0 %h",
                           i, wlog[i].cyc - c0, wlog[i].src, wlog[i].word, 1 + i, fword(b[i]));
      end
    end
    checks++;
    if (wlog.size() == 3 && wlog[2].word[73:66] !== 8'h0F) begin
      errors++; $display("FAIL single_keep8 got %h want 0f", wlog[2].word[73:66]);
    end
    checks++;
    if (pkt_cnt0 !== 32'd1 || pkt_cnt1 !== 32'd0) begin
      errors++; $display("FAIL single_pkt got %0d/%0d want 1/0", pkt_cnt0, pkt_cnt1);
    end
  endtask

  task automatic test_tie();
    beat_t a[2], b[2];
    int c0;
    int exp_cyc[4] = '{1, 2, 4, 5};
    logic [73:0] exp_w[4];
    logic exp_src[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    a[0] = mk(2'b11, 1'b0, 0); a[1] = mk(2'b11, 1'b1, 0);
    b[0] = mk(2'b11, 1'b0, 0); b[1] = mk(2'b10, 1'b1, 0);
    q0.push_back(a[0]); q0.push_back(a[1]); q1.push_back(b[0]); q1.push_back(b[1]);
    exp_w = '{fword(a[0]), fword(a[1]), fword(b[0]), fword(b[1])};
    c0 = cyc;
    for (int i = 0; i < 30 && (q0.size() > 0 || q1.size() > 0); i++) drive_cycle(1'b0);
    repeat (2) drive_cycle(1'b0);
    checks++;
    if (wlog.size() != 4) begin errors++; $display("FAIL tie_cnt got %0d want 4", wlog.size()); end
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      checks++;
      if (wlog[i].src !== exp_src[i] || wlog[i].cyc != c0 + exp_cyc[i] || wlog[i].word !== exp_w[i]) begin
        errors++; $display("FAIL tie_w%0d got src %b cyc %0d want src %b cyc %0d", i, wlog[i].src,
                           wlog[i].cyc - c0, exp_src[i], exp_cyc[i]);
      end
    end
    checks++;
    if (pkt_cnt0 !== 32'd1 || pkt_cnt1 !== 32'd1) begin
      errors++; $display("FAIL tie_pkt got %0d/%0d want 1/1", pkt_cnt0, pkt_cnt1);
    end
  endtask

  task automatic test_full_stall();
    beat_t b[4];
    int c0, bad;
    do_reset();
    for (int i = 0; i < 4; i++) begin b[i] = mk(2'(i), i == 3, 0); q1.push_back(b[i]); end
    c0 = cyc; bad = 0;
    for (int i = 0; i < 40 && q1.size() > 0; i++) begin
      drive_cycle(i >= 2 && i < 7);
      if (i >= 2 && i < 7 && (smp_rdy1 || smp_wr)) bad++;
    end
    repeat (2) drive_cycle(1'b0);
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_rdy got %0d active cycles want 0", bad); end
    checks++;
    if (wlog.size() != 4) begin errors++; $display("FAIL stall_cnt got %0d want 4", wlog.size()); end
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      checks++;
      if (wlog[i].src !== 1'b1 || wlog[i].word !== fword(b[i])) begin
        errors++; $display("FAIL stall_w%0d got %b %h want 1 %h", i, wlog[i].src, wlog[i].word, fword(b[i]));
      end
    end
    checks++;
    if (wlog.size() > 1 && wlog[1].cyc != c0 + 7) begin
      errors++; $display("FAIL stall_resume got cyc %0d want 7", wlog[1].cyc - c0);
    end
    checks++;
    if (abort_cnt !== 16'd0 || pkt_cnt1 !== 32'd1 || viol != 0) begin
      errors++; $display("FAIL stall_cnt2 got abort %0d pkt1 %0d viol %0d want 0 1 0", abort_cnt, pkt_cnt1, viol);
    end
  endtask

  task automatic test_timeout();
    beat_t b[4];
    int c0;
    do_reset();
    b[0] = mk(2'b11, 1'b0, 0); b[1] = mk(2'b11, 1'b0, 10); b[2] = mk(2'b11, 1'b0, 0); b[3] = mk(2'b01, 1'b1, 0);
    for (int i = 0; i < 4; i++) q0.push_back(b[i]);
    c0 = cyc;
    // FIFO goes full during the drain: discard must keep going
    for (int i = 0; i < 60 && q0.size() > 0; i++) drive_cycle(i >= 8);
    repeat (2) drive_cycle(1'b0);
    checks++;
    if (q0.size() != 0) begin errors++; $display("FAIL to_drain got %0d beats left want 0", q0.size()); end
    checks++;
    if (wlog.size() != 2) begin errors++; $display("FAIL to_cnt got %0d writes want 2", wlog.size()); end
    checks++;
    if (wlog.size() > 0 && (wlog[0].word !== fword(b[0]) || wlog[0].cyc != c0 + 1)) begin
      errors++; $display("FAIL to_w0 got %h want %h", wlog[0].word, fword(b[0]));
    end
    checks++;
    if (wlog.size() > 1 && (wlog[1].word !== TERM || wlog[1].src !== 1'b0 || wlog[1].cyc != c0 + 5)) begin
      errors++; $display("FAIL to_term got %h src %b cyc %0d want %h src 0 cyc 5", wlog[1].word, wlog[1].src,
                         wlog[1].cyc - c0, TERM);
    end
    checks++;
    if (abort_cnt !== 16'd1 || pkt_cnt0 !== 32'd0 || viol != 0) begin
      errors++; $display("FAIL to_cnt2 got abort %0d pkt0 %0d viol %0d want 1 0 0", abort_cnt, pkt_cnt0, viol);
    end
  endtask

  task automatic test_reset_mid();
    beat_t s, p[2];
    int c0;
    // no reset here: abort_cnt carries 1 over from the timeout test
    wlog.delete();
    s = mk(2'b10, 1'b1, 0);
    q0.push_back(s);
    for (int i = 0; i < 20 && q0.size() > 0; i++) drive_cycle(1'b0);
    drive_cycle(1'b0);
    checks++;
    if (wlog.size() != 1 || wlog[0].word !== fword(s) || pkt_cnt0 !== 32'd1) begin
      errors++; $display("FAIL onebeat got %0d writes pkt0 %0d want 1 1", wlog.size(), pkt_cnt0);
    end
    wlog.delete();
    for (int i = 0; i < 4; i++) q1.push_back(mk(2'b11, i == 3, 0));
    drive_cycle(1'b0);
    drive_cycle(1'b0);
    checks++;
    if (wlog.size() != 1 || q1.size() != 3) begin
      errors++; $display("FAIL rmid_pre got %0d writes %0d left want 1 3", wlog.size(), q1.size());
    end
    sys_rst_n = 1'b0;
    drive_cycle(1'b0);
    checks++;
    if (smp_rdy1 !== 1'b0 || smp_wr !== 1'b0) begin
      errors++; $display("FAIL rmid_in rdy1 %b wr %b want 0 0", smp_rdy1, smp_wr);
    end
    // upstream flushes its own half packet; s0 offers a new one at once
    q1.delete(); w1 = 0;
    p[0] = mk(2'b11, 1'b0, 0); p[1] = mk(2'b01, 1'b1, 0);
    q0.push_back(p[0]); q0.push_back(p[1]);
    sys_rst_n = 1'b1;
    wlog.delete();
    c0 = cyc;
    drive_cycle(1'b0);
    checks++;
    if ({smp_rdy0, smp_rdy1, smp_wr, smp_src} !== 4'b0000 || smp_din !== 74'd0) begin
      errors++; $display("FAIL rmid_after rdy0/rdy1/wr/src=%b din=%h want 0", {smp_rdy0, smp_rdy1, smp_wr, smp_src}, smp_din);
    end
    checks++;
    if (pkt_cnt0 !== 32'd0 || pkt_cnt1 !== 32'd0 || abort_cnt !== 16'd0) begin
      errors++; $display("FAIL rmid_cnt got %0d/%0d/%0d want 0/0/0", pkt_cnt0, pkt_cnt1, abort_cnt);
    end
    for (int i = 0; i < 20 && q0.size() > 0; i++) drive_cycle(1'b0);
    drive_cycle(1'b0);
    checks++;
    if (wlog.size() != 2 || wlog[0].word !== fword(p[0]) || wlog[1].word !== fword(p[1]) ||
        wlog[0].cyc != c0 + 1 || pkt_cnt0 !== 32'd1) begin
      errors++; $display("FAIL rmid_next got %0d writes pkt0 %0d want 2 1", wlog.size(), pkt_cnt0);
    end
  endtask

  task automatic test_random();
    logic [73:0] exp0[$], exp1[$], e;
    int n = 12, len, il = 0;
    logic cur = 1'b0;
    bit mid = 1'b0;
    beat_t b;
    do_reset();
    for (int p = 0; p < n; p++) begin
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        b = mk(2'($urandom_range(0, 3)), k == len - 1, (k == 0) ? $urandom_range(0, 3) : 0);
        q0.push_back(b); exp0.push_back(fword(b));
      end
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        b = mk(2'($urandom_range(0, 3)), k == len - 1, (k == 0) ? $urandom_range(0, 3) : 0);
        q1.push_back(b); exp1.push_back(fword(b));
      end
    end
    for (int i = 0; i < 2000 && (q0.size() > 0 || q1.size() > 0); i++) drive_cycle($urandom_range(0, 3) == 0);
    repeat (3) drive_cycle(1'b0);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL rnd_done got %0d/%0d beats left want 0/0", q0.size(), q1.size());
    end
    foreach (wlog[i]) begin
      if (mid && wlog[i].src !== cur) il++;
      cur = wlog[i].src;
      mid = !wlog[i].word[1];
      e = 'x;
      if (wlog[i].src === 1'b0 && exp0.size() > 0) e = exp0.pop_front();
      else if (wlog[i].src === 1'b1 && exp1.size() > 0) e = exp1.pop_front();
      checks++;
      if (wlog[i].word !== e) begin
        errors++; $display("FAIL rnd_w%0d src %b got %h want %h", i, wlog[i].src, wlog[i].word, e);
      end
    end
    checks++;
    if (exp0.size() != 0 || exp1.size() != 0 || il != 0) begin
      errors++; $display("FAIL rnd_seq got %0d/%0d unwritten %0d interleaves want 0/0 0", exp0.size(), exp1.size(), il);
    end
    checks++;
    if (pkt_cnt0 !== 32'(n) || pkt_cnt1 !== 32'(n) || abort_cnt !== 16'd0 || viol != 0) begin
      errors++; $display("FAIL rnd_cnt got %0d/%0d abort %0d viol %0d want %0d/%0d 0 0",
                         pkt_cnt0, pkt_cnt1, abort_cnt, viol, n, n);
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; viol = 0; w0 = 0; w1 = 0;
    test_reset();
    test_single_port();
    test_tie();
    test_full_stall();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
